// File: rtl/apb_master.sv
// Single-outstanding APB requester: valid/ready command in, SETUP/ACCESS transfer,
// valid/ready response out, with an optional ACCESS-phase timeout.
module apb_master #(
  parameter int DW      = 32,
  parameter int AW      = 5,
  parameter int TIMEOUT = 16
) (
  input  logic          pclk,
  input  logic          presetn,
  // command side
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_write,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_wdata,
  // response side
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          rsp_timeout,
  // APB requester
  output logic [AW-1:0] paddr,
  output logic          psel,
  output logic          penable,
  output logic          pwrite,
  output logic [DW-1:0] pwdata,
  input  logic          pready,
  input  logic [DW-1:0] prdata,
  input  logic          pslverr
);

  // Counter keeps at least one bit so TIMEOUT=0 (timeout disabled) still elaborates.
  localparam int            CW       = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit            TO_EN    = (TIMEOUT > 0);
  localparam logic [CW-1:0] CNT_MAX  = '1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : CW'(0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] wait_cnt_reg, wait_cnt_next;
  logic [AW-1:0] paddr_reg, paddr_next;
  logic [DW-1:0] pwdata_reg, pwdata_next;
  logic          pwrite_reg, pwrite_next;
  logic          psel_reg, psel_next;
  logic          penable_reg, penable_next;
  logic          rsp_valid_reg, rsp_valid_next;
  logic [DW-1:0] rsp_rdata_reg, rsp_rdata_next;
  logic          rsp_err_reg, rsp_err_next;
  logic          rsp_timeout_reg, rsp_timeout_next;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_reg       <= IDLE;
      wait_cnt_reg    <= '0;
      paddr_reg       <= '0;
      pwdata_reg      <= '0;
      pwrite_reg      <= 1'b0;
      psel_reg        <= 1'b0;
      penable_reg     <= 1'b0;
      rsp_valid_reg   <= 1'b0;
      rsp_rdata_reg   <= '0;
      rsp_err_reg     <= 1'b0;
      rsp_timeout_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      wait_cnt_reg    <= wait_cnt_next;
      paddr_reg       <= paddr_next;
      pwdata_reg      <= pwdata_next;
      pwrite_reg      <= pwrite_next;
      psel_reg        <= psel_next;
      penable_reg     <= penable_next;
      rsp_valid_reg   <= rsp_valid_next;
      rsp_rdata_reg   <= rsp_rdata_next;
      rsp_err_reg     <= rsp_err_next;
      rsp_timeout_reg <= rsp_timeout_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    wait_cnt_next    = wait_cnt_reg;
    paddr_next       = paddr_reg;
    pwdata_next      = pwdata_reg;
    pwrite_next      = pwrite_reg;
    rsp_rdata_next   = rsp_rdata_reg;
    rsp_err_next     = rsp_err_reg;
    rsp_timeout_next = rsp_timeout_reg;

    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          paddr_next  = cmd_addr;
          pwdata_next = cmd_wdata;
          pwrite_next = cmd_write;
          state_next  = SETUP;
        end
      end
      SETUP: begin
        wait_cnt_next = '0;
        state_next    = ACCESS;
      end
      ACCESS: begin
        // A completing pready outranks a timeout landing in the same cycle.
        if (pready) begin
          rsp_rdata_next   = pwrite_reg ? '0 : prdata;
          rsp_err_next     = pslverr;
          rsp_timeout_next = 1'b0;
          state_next       = RESP;
        end else if (TO_EN && (wait_cnt_reg == CNT_LAST)) begin
          rsp_rdata_next   = '0;
          rsp_err_next     = 1'b1;
          rsp_timeout_next = 1'b1;
          state_next       = RESP;
        end else if (wait_cnt_reg != CNT_MAX) begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // APB and response strobes are registered copies of the upcoming state.
    psel_next      = (state_next == SETUP) || (state_next == ACCESS);
    penable_next   = (state_next == ACCESS);
    rsp_valid_next = (state_next == RESP);
  end

  assign cmd_ready   = (state_reg == IDLE);
  assign paddr       = paddr_reg;
  assign pwdata      = pwdata_reg;
  assign pwrite      = pwrite_reg;
  assign psel        = psel_reg;
  assign penable     = penable_reg;
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_rdata   = rsp_rdata_reg;
  assign rsp_err     = rsp_err_reg;
  assign rsp_timeout = rsp_timeout_reg;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master: APB slave model with wait states / errors,
// response scoreboard with due-cycle tracking, backpressure and reset-abort cases.
module tb_apb_master;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int TO = 16;

  logic          pclk;
  logic          presetn;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [AW-1:0] paddr;
  logic          psel, penable, pwrite;
  logic [DW-1:0] pwdata;
  logic          pready, pslverr;
  logic [DW-1:0] prdata;

  apb_master #(.DW(DW), .AW(AW), .TIMEOUT(TO)) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
    .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  typedef struct {
    logic [DW-1:0] rdata;
    logic          err;
    logic          to;
    int            due;
  } exp_t;

  exp_t          sb_q[$];
  int            err_cnt = 0;
  int            chk_cnt = 0;
  int            cyc = 0;
  int            acc_edge = 0;
  logic [AW-1:0] cur_addr;
  logic          cur_write;
  logic [DW-1:0] cur_wdata;
  logic [DW-1:0] ref_mem [32];
  logic [DW-1:0] slv_mem [32];
  int            slv_wait = 0;
  int            slv_cnt = 0;
  logic          slv_err = 0;
  logic          slv_dead = 0;
  logic          slv_ovr = 0;
  logic [DW-1:0] slv_ovr_val = '0;
  logic          prev_psel = 0;
  logic          prev_rv = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    pclk = 0;
    forever #5 pclk = ~pclk;
  end

  initial forever begin
    @(posedge pclk);
    cyc++;
  end

  // APB slave: garbage on prdata/pslverr except in the completing ACCESS cycle
  initial begin
    pready = 0; pslverr = 0; prdata = '0;
    for (int i = 0; i < 32; i++) begin
      slv_mem[i] = '0;
      ref_mem[i] = '0;
    end
    forever begin
      @(negedge pclk);
      pready = 0; pslverr = 1; prdata = 32'hBAD0_BAD0;
      if (psel && !penable) begin
        slv_cnt = slv_wait;
      end else if (psel && penable && !slv_dead) begin
        if (slv_cnt == 0) begin
          pready  = 1;
          pslverr = slv_err;
          if (!pwrite) prdata = slv_ovr ? slv_ovr_val : slv_mem[paddr];
          else slv_mem[paddr] = pwdata;
        end else begin
          slv_cnt--;
        end
      end
    end
  end

  // APB request monitor
  initial forever begin
    @(negedge pclk);
    if (presetn && psel) begin
      check("paddr", paddr, cur_addr);
      check("pwrite", pwrite, cur_write);
      if (cur_write) check("pwdata", pwdata, cur_wdata);
      check("cmd_ready_busy", cmd_ready, 0);
      if (!prev_psel) begin
        check("setup_penable", penable, 0);
        check("setup_cyc", cyc, acc_edge);
      end
    end
    prev_psel = psel;
  end

  // Response scoreboard consumer
  initial forever begin
    @(negedge pclk);
    if (presetn && rsp_valid) begin
      if (!prev_rv) begin
        check("q_nonempty", (sb_q.size() != 0), 1);
        if (sb_q.size() != 0) check("rsp_cyc", cyc, sb_q[0].due);
      end
      check("psel_in_resp", psel, 0);
      if (sb_q.size() != 0) begin
        check("rsp_rdata", rsp_rdata, sb_q[0].rdata);
        check("rsp_err", rsp_err, sb_q[0].err);
        check("rsp_timeout", rsp_timeout, sb_q[0].to);
        if (rsp_ready) begin
          $display("rsp @%0d rdata=%08h err=%0d timeout=%0d", cyc, rsp_rdata, rsp_err, rsp_timeout);
          void'(sb_q.pop_front());
        end
      end
    end
    prev_rv = rsp_valid;
  end

  // Called and returns 1 time unit after a rising edge.
  task automatic do_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    bit   ok;
    ok = 0;
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    for (int i = 0; i < 60; i++) begin
      if (cmd_ready) begin
        @(posedge pclk); #1;
        ok = 1;
        break;
      end
      @(posedge pclk); #1;
    end
    cmd_valid = 0;
    check("cmd_accept", ok, 1);
    if (ok) begin
      acc_edge = cyc;
      cur_addr = a; cur_write = wr; cur_wdata = d;
      if (slv_dead) begin
        e.rdata = '0; e.err = 1; e.to = 1; e.due = acc_edge + 1 + TO;
      end else begin
        e.rdata = wr ? '0 : (slv_ovr ? slv_ovr_val : ref_mem[a]);
        e.err   = slv_err;
        e.to    = 0;
        e.due   = acc_edge + 2 + slv_wait;
        if (wr) ref_mem[a] = d;
      end
      $display("cmd @%0d %s addr=%02h wdata=%08h", acc_edge, wr ? "WR" : "RD", a, d);
      sb_q.push_back(e);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb_q.size() != 0; i++) begin
      @(posedge pclk); #1;
    end
    check("drain", sb_q.size(), 0);
  endtask

  int first_edge, rel_edge;
  bit seen;

  initial begin
    presetn = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1; cur_addr = '0; cur_write = 0; cur_wdata = '0;
    #2 presetn = 0;
    repeat (2) @(posedge pclk);
    #1;
    check("rst_psel", psel, 0);
    check("rst_penable", penable, 0);
    check("rst_pwrite", pwrite, 0);
    check("rst_paddr", paddr, 0);
    check("rst_pwdata", pwdata, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_timeout", rsp_timeout, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    presetn = 1;
    @(posedge pclk); #1;

    // zero-wait write, then read-back with 3 wait states
    do_cmd(1, 5'h04, 32'hDEAD_BEEF); drain();
    slv_wait = 3;
    do_cmd(0, 5'h04, '0); drain();

    // slave error on read with explicit data
    slv_wait = 1; slv_err = 1; slv_ovr = 1; slv_ovr_val = 32'h0000_1234;
    do_cmd(0, 5'h04, '0); drain();
    slv_wait = 0; slv_err = 0; slv_ovr = 0;

    // back-to-back writes: one transfer per 4 cycles
    do_cmd(1, 5'h10, 32'h1111_2222);
    first_edge = acc_edge;
    do_cmd(1, 5'h11, 32'h3333_4444);
    check("b2b_spacing", acc_edge - first_edge, 4);
    drain();
    do_cmd(0, 5'h11, '0); drain();

    // dead slave times out; pready in the last allowed cycle completes normally
    slv_dead = 1;
    do_cmd(0, 5'h10, '0); drain();
    slv_dead = 0; slv_wait = TO - 1;
    do_cmd(0, 5'h10, '0); drain();
    slv_wait = 0;

    // response backpressure with a second command pending
    rsp_ready = 0;
    do_cmd(1, 5'h05, 32'hCAFE_F00D);
    cmd_valid = 1; cmd_write = 0; cmd_addr = 5'h05; cmd_wdata = '0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (rsp_valid) begin seen = 1; break; end
      @(posedge pclk); #1;
    end
    check("bp_rsp_seen", seen, 1);
    for (int i = 0; i < 5; i++) begin
      check("bp_cmd_ready", cmd_ready, 0);
      check("bp_psel", psel, 0);
      @(posedge pclk); #1;
    end
    rsp_ready = 1;
    rel_edge = cyc + 1;
    do_cmd(0, 5'h05, '0);
    check("bp_accept_edge", acc_edge, rel_edge + 1);
    drain();

    // reset asserted during ACCESS aborts the transfer
    slv_wait = 6;
    do_cmd(0, 5'h04, '0);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (penable) begin seen = 1; break; end
      @(posedge pclk); #1;
    end
    check("rst_access_seen", seen, 1);
    #2 presetn = 0;
    #1;
    check("arst_psel", psel, 0);
    check("arst_penable", penable, 0);
    check("arst_rsp_valid", rsp_valid, 0);
    sb_q.delete();
    @(posedge pclk); #1;
    check("arst_cmd_ready", cmd_ready, 1);
    presetn = 1;
    slv_wait = 0;
    @(posedge pclk); #1;
    do_cmd(1, 5'h07, 32'h5A5A_A5A5); drain();
    do_cmd(0, 5'h07, '0); drain();

    repeat (3) @(posedge pclk);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/apb_master.md
# apb_master

Single-outstanding APB requester that turns a valid/ready command interface into compliant APB SETUP/ACCESS transfers and returns each result on a valid/ready response interface. It is the initiator side for the team's APB register slaves: it drives `paddr/psel/penable/pwrite/pwdata` and samples `pready/prdata/pslverr`. A programmable ACCESS-phase timeout keeps a dead slave from hanging the bus.

## Interface
- `DW`, 32, data width of APB and command/response data
- `AW`, 5, APB address width
- `TIMEOUT`, 16, maximum ACCESS cycles waited for `pready`; 0 disables the timeout
- `pclk`  in  1  clock; all logic on rising edge
- `presetn`  in  1  reset, asynchronous, active-low
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  command accepted when high with `cmd_valid`
- `cmd_write`  in  1  1 = write, 0 = read
- `cmd_addr`  in  AW  target address
- `cmd_wdata`  in  DW  write data (ignored for reads)
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  response consumed when high with `rsp_valid`
- `rsp_rdata`  out  DW  read data; 0 for writes and timed-out transfers
- `rsp_err`  out  1  `pslverr` sampled at completion, or timeout
- `rsp_timeout`  out  1  transfer aborted by timeout
- `paddr`  out  AW; `psel`  out  1; `penable`  out  1; `pwrite`  out  1; `pwdata`  out  DW  APB request
- `pready`  in  1; `prdata`  in  DW; `pslverr`  in  1  APB completion

## Operation
- FSM states IDLE, SETUP, ACCESS, RESP; reset state IDLE.
- IDLE: `cmd_ready`=1. On `cmd_valid`: register `cmd_write/addr/wdata` into `pwrite/paddr/pwdata`, go SETUP.
- SETUP: `psel`=1, `penable`=0; clear wait counter; always go ACCESS next cycle.
- ACCESS: `psel`=1, `penable`=1. If `pready`=1: capture `prdata` (reads; 0 for writes) into `rsp_rdata`, `pslverr` into `rsp_err`, `rsp_timeout`=0, go RESP. Else increment wait counter.
- Timeout: if `TIMEOUT`≠0 and `pready` is still low in the TIMEOUT-th ACCESS cycle, terminate: `rsp_rdata`=0, `rsp_err`=1, `rsp_timeout`=1, go RESP. `pready` high in that same cycle wins (normal completion).
- RESP: `psel`=`penable`=0, `rsp_valid`=1; response fields held stable until `rsp_ready`, then IDLE.
- `cmd_ready` is 0 outside IDLE; one transfer outstanding at most.
- `paddr`, `pwrite`, `pwdata` stable from SETUP through end of ACCESS; outside a transfer they hold last values.
- `pslverr` and `prdata` are ignored except in the ACCESS cycle with `pready`=1.
- Wait counter is `$clog2(TIMEOUT+1)` bits, saturating; never wraps.

## Timing
- All outputs registered except `cmd_ready` (decoded from state).
- Reset values: `psel`,`penable`,`pwrite`,`rsp_valid`,`rsp_err`,`rsp_timeout` = 0; `paddr`,`pwdata`,`rsp_rdata` = 0; `cmd_ready`=1.
- Zero-wait slave: accept at cycle N, SETUP N+1, ACCESS N+2, `rsp_valid` N+3. Each `pready`-low cycle adds one.
- With `rsp_ready` tied high, RESP lasts one cycle, IDLE one cycle: back-to-back throughput one transfer per 4 cycles.
- `rsp_ready` low holds RESP indefinitely; APB idle meanwhile.
- `presetn` asserted mid-transfer: `psel/penable` drop immediately (asynchronously), pending command and response discarded, FSM to IDLE.

## Test plan
- Write 0xDEADBEEF to 0x04, zero-wait slave -> SETUP at N+1 (`psel`=1,`penable`=0), ACCESS N+2, `rsp_valid` N+3 with `rsp_rdata`=0, `rsp_err`=0.
- Read 0x04 after that write, slave inserts 3 wait states -> `paddr` stable 0x04 throughout, `rsp_valid` at N+6, `rsp_rdata`=0xDEADBEEF.
- Read with `pslverr`=1 at completion, `prdata`=0x1234 -> `rsp_err`=1, `rsp_timeout`=0, `rsp_rdata`=0x1234.
- TIMEOUT=16, `pready` held low -> 16 ACCESS cycles, then `psel`=0 and `rsp_valid`=1 with `rsp_err`=1, `rsp_timeout`=1, `rsp_rdata`=0; `pready` rising in cycle 16 instead -> normal completion.
- `rsp_ready` low 5 cycles with a second `cmd_valid` pending -> `rsp_*` stable, `cmd_ready`=0, no `psel`; after handshake, second command accepted one cycle later.
- `presetn` pulsed low during ACCESS -> `psel`,`penable`,`rsp_valid` 0 the same cycle; after release `cmd_ready`=1, next write completes normally.
